vend_ctrl: RTL
==============

# vend_ctrl

Parametrised vending-machine controller core: accumulates coin credit, checks selections against a per-item price table and per-item stock counters, vends, returns change, and rejects invalid requests. It is the next-generation vending state machine, instantiated under `top` and clocked by `hz100`. Push-button decoding, display and UART handling stay in `top`. An optional inactivity timeout auto-refunds abandoned credit.

## Interface
- `NUM_ITEMS`, 4: number of selectable items (1..16).
- `CREDIT_W`, 8: width of credit, price, coin and refund values.
- `STOCK_W`, 3: per-item stock counter width. Full stock is 2^STOCK_W−1.
- `MAX_CREDIT`, 200: credit ceiling (≤ 2^CREDIT_W−1).
- `TIMEOUT_CYC`, 1000: idle cycles before auto-refund (10 s at 100 Hz).
- `IDX_W` (local): max(1, clog2(NUM_ITEMS)).

Ports:
- `hz100` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `coin_valid` in 1: one-cycle coin strobe.
- `coin_value` in CREDIT_W: coin value, sampled with `coin_valid`.
- `sel_valid` in 1: one-cycle selection strobe.
- `sel_idx` in IDX_W: selected item.
- `refund_req` in 1: one-cycle refund request.
- `restock_valid` in 1: restock strobe.
- `restock_idx` in IDX_W: item to restock.
- `price_tbl` in NUM_ITEMS*CREDIT_W: item i price at bits [i*CREDIT_W +: CREDIT_W]. Static during use.
- `state` out 3: current state.
- `credit` out CREDIT_W: current credit.
- `vend_valid` out 1: one-cycle vend pulse.
- `vend_idx` out IDX_W: vended item.
- `refund_valid` out 1: one-cycle refund pulse.
- `refund_amt` out CREDIT_W: amount refunded.
- `reject` out 1: one-cycle rejection pulse.
- `coin_ret` out 1: one-cycle pulse; the coin offered the previous cycle was returned.
- `stock` out NUM_ITEMS*STOCK_W: stock counters.

## Operation
- State encoding: INIT=0, MONEY=1, PURCHASED=2, REJECTION=3, REFUND=4. Codes 5–7 are unreachable; if entered, the next state is INIT.
- Reset:
  - state=INIT, credit=0.
  - Every stock counter at full.
  - All pulse outputs 0; vend_idx=0, refund_amt=0.
- Coin acceptance:
  - A coin is accepted only in INIT/MONEY, when no sel_valid/refund_req is in the same cycle, and when credit+coin_value ≤ MAX_CREDIT. Sum uses CREDIT_W+1 bits; no wrap.
  - Accepted: credit += coin_value; state → MONEY.
  - Otherwise: coin_ret pulses next cycle and credit is unchanged. This covers over-ceiling coins, coins in any other state, and coins colliding with a selection or refund.
- Input priority in INIT/MONEY: refund_req > sel_valid > coin_valid.
- INIT: sel_valid → REJECTION. refund_req is ignored (credit 0).
- MONEY:
  - refund_req → REFUND.
  - sel_valid → REJECTION if sel_idx ≥ NUM_ITEMS, stock[sel_idx]==0, or credit < price. Otherwise → PURCHASED.
- PURCHASED (1 cycle):
  - vend_valid=1, vend_idx=selected item.
  - credit −= price; stock[item] −= 1.
  - Next: REFUND if the remaining credit > 0, else INIT.
- REFUND (1 cycle): refund_valid=1, refund_amt=credit, credit←0, next INIT.
- REJECTION (1 cycle): reject=1, credit retained. Next: MONEY if credit > 0, else INIT.
- Restock: accepted only in INIT. Sets stock[restock_idx] to full. Ignored in other states or when restock_idx ≥ NUM_ITEMS.
- vend_idx and refund_amt hold their last value between pulses.

## Timing
- All outputs are registered.
- Coin accepted in cycle N → credit updated at N+1.
- Selection in cycle N:
  - Success: state=PURCHASED at N+1; vend_valid high during N+1; credit and stock updated at N+2; change refund_valid during N+2.
  - Rejection: reject high during N+1.
- refund_req in cycle N → refund_valid during N+1; credit=0 at N+2.
- coin_ret in cycle N+1 for a coin returned in cycle N.
- Exact-price purchase: no REFUND cycle; INIT at N+2.
- Reset has priority over every input in the same cycle.
- Reset mid-PURCHASED discards the pending stock decrement and credit: everything returns to reset values.

## Configuration
- `VEND_TIMEOUT_EN` defined:
  - Idle counter, width clog2(TIMEOUT_CYC+1), cleared on entering MONEY and on every coin_valid/sel_valid/refund_req.
  - Increments each cycle in MONEY. On reaching TIMEOUT_CYC−1 the next state is REFUND.
  - The counter is held at 0 outside MONEY.
- Undefined: no counter; credit persists in MONEY indefinitely.

## Test plan
- Default params, prices {50,75,100,25}: coins 25,25,25, then sel 1 → vend_valid with vend_idx=1, credit 0, stock[1]=6, back to INIT, no refund_valid.
- Coins 100,25, sel 0 (price 50) → vend_valid, then refund_valid with refund_amt=75, then INIT.
- credit=190, coin 25 → coin_ret pulse, credit stays 190. Coin during PURCHASED → coin_ret.
- Sel an item with stock 0, or credit 20 < price 25 → reject pulse, credit unchanged, state MONEY. Restock in INIT → stock full.
- Same cycle refund_req + sel + coin with credit 50 → REFUND with amt 50, coin_ret, no vend.
- With `VEND_TIMEOUT_EN`, TIMEOUT_CYC=10: coin 25 then idle → refund_valid with amt 25 exactly 10 cycles after entering MONEY. Reset mid-sequence → credit 0, INIT.

Source files
------------

// File: rtl/vend_ctrl.sv
// Vending-machine controller: coin credit, price/stock checks, vend, change and refund.
// Define VEND_TIMEOUT_EN to auto-refund credit left idle in MONEY for TIMEOUT_CYC cycles.
module vend_ctrl #(
    parameter int NUM_ITEMS   = 4,
    parameter int CREDIT_W    = 8,
    parameter int STOCK_W     = 3,
    parameter int MAX_CREDIT  = 200,
    parameter int TIMEOUT_CYC = 1000,
    localparam int IDX_W      = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
    input  logic                          hz100,
    input  logic                          reset,
    input  logic                          coin_valid,
    input  logic [CREDIT_W-1:0]           coin_value,
    input  logic                          sel_valid,
    input  logic [IDX_W-1:0]              sel_idx,
    input  logic                          refund_req,
    input  logic                          restock_valid,
    input  logic [IDX_W-1:0]              restock_idx,
    input  logic [NUM_ITEMS*CREDIT_W-1:0] price_tbl,
    output logic [2:0]                    state,
    output logic [CREDIT_W-1:0]           credit,
    output logic                          vend_valid,
    output logic [IDX_W-1:0]              vend_idx,
    output logic                          refund_valid,
    output logic [CREDIT_W-1:0]           refund_amt,
    output logic                          reject,
    output logic                          coin_ret,
    output logic [NUM_ITEMS*STOCK_W-1:0]  stock
);

    typedef enum logic [2:0] {
        StInit      = 3'd0,
        StMoney     = 3'd1,
        StPurchased = 3'd2,
        StRejection = 3'd3,
        StRefund    = 3'd4
    } st_e;

    localparam logic [STOCK_W-1:0] StockFull = {STOCK_W{1'b1}};

`ifdef VEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

    st_e                 fsm;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;
    logic                sel_bad;
    logic [CREDIT_W-1:0] sel_price;
    logic [CREDIT_W-1:0] item_price;
    logic [CREDIT_W-1:0] credit_left;
    logic [STOCK_W-1:0]  sel_stock;

    assign state = fsm;

    always_comb begin
        sel_price  = '0;
        item_price = '0;
        sel_stock  = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_price = price_tbl[i*CREDIT_W +: CREDIT_W];
                sel_stock = stock[i*STOCK_W +: STOCK_W];
            end
            if (vend_idx == IDX_W'(i)) begin
                item_price = price_tbl[i*CREDIT_W +: CREDIT_W];
            end
        end
        // One extra bit so an over-ceiling coin cannot wrap into range.
        coin_sum    = {1'b0, credit} + {1'b0, coin_value};
        coin_fits   = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
        sel_bad     = (32'(sel_idx) >= NUM_ITEMS) || (sel_stock == '0) || (credit < sel_price);
        credit_left = credit - item_price;
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            fsm          <= StInit;
            credit       <= '0;
            stock        <= {NUM_ITEMS{StockFull}};
            vend_valid   <= 1'b0;
            vend_idx     <= '0;
            refund_valid <= 1'b0;
            refund_amt   <= '0;
            reject       <= 1'b0;
            coin_ret     <= 1'b0;
`ifdef VEND_TIMEOUT_EN
            idle         <= '0;
`endif
        end else begin
            vend_valid   <= 1'b0;
            refund_valid <= 1'b0;
            reject       <= 1'b0;
            // Any coin is returned unless the accept branch below clears this.
            coin_ret     <= coin_valid;
`ifdef VEND_TIMEOUT_EN
            idle         <= '0;
`endif
            if (restock_valid && fsm == StInit) begin
                for (int i = 0; i < NUM_ITEMS; i++) begin
                    if (restock_idx == IDX_W'(i)) begin
                        stock[i*STOCK_W +: STOCK_W] <= StockFull;
                    end
                end
            end

            case (fsm)
                StInit, StMoney: begin
                    if (refund_req && fsm == StMoney) begin
                        fsm          <= StRefund;
                        refund_valid <= 1'b1;
                        refund_amt   <= credit;
                    end else if (sel_valid) begin
                        if (fsm == StInit || sel_bad) begin
                            fsm    <= StRejection;
                            reject <= 1'b1;
                        end else begin
                            fsm        <= StPurchased;
                            vend_valid <= 1'b1;
                            vend_idx   <= sel_idx;
                        end
                    end else if (coin_valid) begin
                        if (!refund_req && coin_fits) begin
                            credit   <= coin_sum[CREDIT_W-1:0];
                            fsm      <= StMoney;
                            coin_ret <= 1'b0;
                        end
                    end
`ifdef VEND_TIMEOUT_EN
                    else if (fsm == StMoney) begin
                        if (idle == TO_W'(TIMEOUT_CYC - 1)) begin
                            fsm          <= StRefund;
                            refund_valid <= 1'b1;
                            refund_amt   <= credit;
                        end else begin
                            idle <= idle + 1'b1;
                        end
                    end
`endif
                end

                StPurchased: begin
                    for (int i = 0; i < NUM_ITEMS; i++) begin
                        if (vend_idx == IDX_W'(i)) begin
                            stock[i*STOCK_W +: STOCK_W] <= stock[i*STOCK_W +: STOCK_W] - 1'b1;
                        end
                    end
                    credit <= credit_left;
                    if (credit_left != '0) begin
                        fsm          <= StRefund;
                        refund_valid <= 1'b1;
                        refund_amt   <= credit_left;
                    end else begin
                        fsm <= StInit;
                    end
                end

                StRejection: begin
                    fsm <= (credit != '0) ? StMoney : StInit;
                end

                StRefund: begin
                    credit <= '0;
                    fsm    <= StInit;
                end

                default: begin
                    fsm <= StInit;
                end
            endcase
        end
    end

endmodule
